comb_filter_feedback: RTL

Recursive (IIR) comb filter, the feedback counterpart of the feedforward comb in the audio effects chain: y[n] = x[n] + g*y[n-DELAY].
Processes one signed 16-bit sample per sample_valid strobe, i.e. at the audio sample rate, not every clock.
Keeps its own output history in an internal circular buffer (inferred dual-port RAM), so feedback comes from past outputs, not past inputs.
Sits after the input stage and before the mixer in the reverb/echo path.

---
 rtl/comb_filter_feedback.sv | 114 +++++++++++
 1 files changed

// File: rtl/comb_filter_feedback.sv
// Recursive comb filter: y[n] = x[n] + g*y[n-DELAY].
// Output history lives in an inferred dual-port RAM.
module comb_filter_feedback #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2048,
  parameter int DELAY      = 1024,
  parameter int GAIN_FRAC  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic        [GAIN_FRAC-1:0]  gain,
  output logic signed [DATA_WIDTH-1:0] audio_out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] DLY = AW'(DELAY);

  logic signed [DW-1:0] mem [DEPTH];

  logic                 cmp_q;
  logic                 vld_q;
  logic                 ovr_q;
  logic signed [DW-1:0] x_q;
  logic [GAIN_FRAC-1:0] g_q;
  logic signed [DW-1:0] rd_q;
  logic signed [DW-1:0] y_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        fill_q, fill_d;

  logic                 busy;
  logic                 accept;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] ydel;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] fb;
  logic signed [DW:0]   sum;
  logic signed [DW-1:0] y_sat;

  assign busy      = cmp_q | vld_q;
  assign accept    = sample_valid & ~busy;
  assign rd_addr   = wr_ptr_q - DLY;
  assign audio_out = y_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;

  // Feedback path: mask unwritten history, scale, add, saturate.
  always_comb begin
    ydel  = (fill_q < DLY) ? '0 : rd_q;
    prod  = $signed({{DW{ydel[DW-1]}}, ydel})
          * $signed({{(PW-GAIN_FRAC){1'b0}}, g_q});
    fb    = prod >>> GAIN_FRAC;
    sum   = (DW+1)'(fb + $signed({{DW{x_q[DW-1]}}, x_q}));
    y_sat = sum[DW-1:0];
    if (sum[DW] != sum[DW-1]) begin
      y_sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                      : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Pointer and fill advance on each committed sample.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (vld_q) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != DLY) fill_d = fill_q + AW'(1);
    end
  end

  // Three-cycle pipeline: accept, compute, commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= 1'b0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      x_q   <= '0;
      g_q   <= '0;
      y_q   <= '0;
    end else begin
      cmp_q <= accept;
      vld_q <= cmp_q;
      if (sample_valid && busy) ovr_q <= 1'b1;
      if (accept) begin
        x_q <= audio_in;
        g_q <= gain;
      end
      if (cmp_q) y_q <= y_sat;
    end
  end

  // History bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // History RAM: write on commit, registered read on accept.
  always_ff @(posedge clk) begin
    if (vld_q) mem[wr_ptr_q] <= y_q;
    if (accept) rd_q <= mem[rd_addr];
  end

endmodule
